// File: rtl/cpu_mem_responder.sv
// Responder end of the CPU toggle request/acknowledge memory protocol, with a shared 8-bit loader write port.
// Optional build macro CPU_MEM_RESPONDER_SYNC_EN: req_toggle passes through a 2-flop synchronizer.
module cpu_mem_responder #(
  parameter int ADDR_W  = 25,
  parameter int LATENCY = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              req_toggle,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_wr_sel,
  input  logic [15:0]       req_din,
  output logic              ack_toggle,
  output logic [15:0]       dout,
  output logic              done,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              load_wr,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_READ_WAIT = 2'd2;
  localparam logic [1:0] S_WRITE     = 2'd3;

  // Counter starts at LATENCY-1 so the completing edge is exactly LATENCY edges after the strobe edge.
  localparam logic [2:0] WAIT_INIT = 3'(LATENCY - 1);

  logic [1:0]        state;
  logic [2:0]        wait_cnt;
  logic              tog_lat;
  logic              req_cmp;
  logic [ADDR_W-1:0] hold_addr;
  logic [7:0]        hold_data;
  logic              unused_bits;

  assign unused_bits = req_addr[0];

`ifdef CPU_MEM_RESPONDER_SYNC_EN
  logic [1:0] req_sync;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) req_sync <= 2'b00;
    else          req_sync <= {req_sync[0], req_toggle};
  end

  assign req_cmp = req_sync[1];
`else
  assign req_cmp = req_toggle;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wait_cnt   <= 3'd0;
      tog_lat    <= 1'b0;
      ack_toggle <= 1'b0;
      dout       <= 16'h0000;
      done       <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 2'b00;
      mem_wdata  <= 16'h0000;
      hold_addr  <= '0;
      hold_data  <= 8'h00;
      load_busy  <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          // A loader write seen on this very edge already wins over a CPU request.
          if (load_wr || load_busy) begin
            state <= S_LOAD;
          end else if (req_cmp != ack_toggle) begin
            tog_lat  <= req_cmp;
            mem_addr <= req_addr[ADDR_W-1:1];
            if (req_wr_sel == 2'b00) begin
              mem_rd   <= 1'b1;
              wait_cnt <= WAIT_INIT;
              state    <= S_READ_WAIT;
            end else begin
              mem_we    <= 1'b1;
              mem_be    <= req_wr_sel;
              mem_wdata <= req_din;
              state     <= S_WRITE;
            end
          end
        end
        S_LOAD: begin
          mem_we    <= 1'b1;
          mem_addr  <= hold_addr[ADDR_W-1:1];
          mem_be    <= hold_addr[0] ? 2'b10 : 2'b01;
          mem_wdata <= {hold_data, hold_data};
          load_busy <= 1'b0;
          state     <= S_IDLE;
        end
        S_READ_WAIT: begin
          if (wait_cnt == 3'd0) begin
            dout       <= mem_rdata;
            ack_toggle <= tog_lat;
            done       <= 1'b1;
            state      <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_WRITE: begin
          ack_toggle <= tog_lat;
          done       <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A new loader strobe overrides the clear issued from S_LOAD on the same edge.
      if (load_wr) begin
        hold_addr <= load_addr;
        hold_data <= load_data;
        load_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: transaction-schedule model plus backing memory, per-cycle compare and literal pins.
`timescale 1ns/1ps
module tb_cpu_mem_responder;
  localparam int ADDR_W = 25;
  localparam int LAT    = 2;
`ifdef CPU_MEM_RESPONDER_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_toggle = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_wr_sel = 2'b00;
  logic [15:0]       req_din = 16'h0000;
  logic              ack_toggle, done, mem_rd, mem_we, load_busy;
  logic [15:0]       dout, mem_wdata;
  logic [15:0]       mem_rdata = 16'h0000;
  logic [ADDR_W-2:0] mem_addr;
  logic [1:0]        mem_be;
  logic              load_wr = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [7:0]        load_data = 8'h00;

  cpu_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_toggle(req_toggle), .req_addr(req_addr),
    .req_wr_sel(req_wr_sel), .req_din(req_din), .ack_toggle(ack_toggle), .dout(dout), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .load_wr(load_wr), .load_addr(load_addr), .load_data(load_data),
    .load_busy(load_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [15:0] init_val(input int a);
    case (a)
      'h82:    return 16'hBEEF;
      'h08:    return 16'h3456;
      'h10:    return 16'h0011;
      'h11:    return 16'hF00D;
      'h20:    return 16'h1234;
      default: return 16'(a * 37 + 3072);
    endcase
  endfunction

  // Backing store: 2-clock synchronous read (strobe edge + 1 registers data, DUT samples one edge later).
  logic [15:0] bmem [256];
  bit          wr_flag [256];

  function automatic logic [15:0] rd_b(input logic [7:0] a);
    return wr_flag[a] ? bmem[a] : init_val(int'(a));
  endfunction

  always @(posedge clk_sys) begin
    if (mem_we) begin
      bmem[mem_addr[7:0]] <= {mem_be[1] ? mem_wdata[15:8] : rd_b(mem_addr[7:0])[15:8],
                              mem_be[0] ? mem_wdata[7:0]  : rd_b(mem_addr[7:0])[7:0]};
      wr_flag[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_rd) mem_rdata <= rd_b(mem_addr[7:0]);
  end

  // Model: per-cycle expectations derived from the protocol timing rules.
  bit          e_rd [4096], e_we [4096], e_done [4096], e_busy [4096], u_v [4096];
  logic [23:0] e_addr [4096];
  logic [1:0]  e_be [4096];
  logic [15:0] e_wd [4096];
  logic        u_ack [4096];
  logic [15:0] u_dout [4096];
  logic [15:0] gm [256];
  int          free_at = 0, cur_acc = 0, t_start = 0;
  logic [15:0] sched_dout = 16'h0000;
  logic        m_ack = 1'b0;
  logic [15:0] m_dout = 16'h0000;
  int          last_rd = -1, last_we = -1;
  logic [23:0] last_rd_addr = '0;
  logic [1:0]  last_we_be = 2'b00;
  logic [15:0] last_we_wd = 16'h0000;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_load(input logic [ADDR_W-1:0] a, input logic [7:0] b);
    int le;
    le = imax(cyc + 1, free_at);
    for (int c = cyc + 1; c <= le; c++) e_busy[c] = 1'b1;
    e_we[le+1]   = 1'b1;
    e_addr[le+1] = a[ADDR_W-1:1];
    e_be[le+1]   = a[0] ? 2'b10 : 2'b01;
    e_wd[le+1]   = {b, b};
    if (a[0]) gm[a[8:1]][15:8] = b;
    else      gm[a[8:1]][7:0]  = b;
    free_at = le + 2;
  endtask

  task automatic model_req(input logic tog, input logic [ADDR_W-1:0] a, input logic [1:0] sel,
                           input logic [15:0] din);
    int acc, d;
    acc = imax(cyc + 1 + SYNC_D, free_at);
    e_addr[acc] = a[ADDR_W-1:1];
    if (sel == 2'b00) begin
      e_rd[acc]  = 1'b1;
      d          = acc + LAT;
      sched_dout = gm[a[8:1]];
      free_at    = d + 1;
    end else begin
      e_we[acc] = 1'b1;
      e_be[acc] = sel;
      e_wd[acc] = din;
      if (sel[1]) gm[a[8:1]][15:8] = din[15:8];
      if (sel[0]) gm[a[8:1]][7:0]  = din[7:0];
      d       = acc + 1;
      free_at = acc + 2;
    end
    e_done[d] = 1'b1;
    u_v[d]    = 1'b1;
    u_ack[d]  = tog;
    u_dout[d] = sched_dout;
    cur_acc   = acc;
  endtask

  // Compare process: every cycle, mid-cycle.
  initial forever begin
    @(negedge clk_sys);
    if (!reset_n) begin
      m_ack  = 1'b0;
      m_dout = 16'h0000;
    end else if (u_v[cyc]) begin
      m_ack  = u_ack[cyc];
      m_dout = u_dout[cyc];
    end
    if (mem_rd) begin last_rd = cyc; last_rd_addr = mem_addr[23:0]; end
    if (mem_we) begin last_we = cyc; last_we_be = mem_be; last_we_wd = mem_wdata; end
    chk("ack_toggle", 32'(ack_toggle), 32'(m_ack));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("done", 32'(done), 32'(e_done[cyc]));
    chk("mem_rd", 32'(mem_rd), 32'(e_rd[cyc]));
    chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
    chk("load_busy", 32'(load_busy), 32'(e_busy[cyc]));
    if (e_rd[cyc] || e_we[cyc]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
    if (e_we[cyc]) begin
      chk("mem_be", 32'(mem_be), 32'(e_be[cyc]));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[cyc]));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_start(input logic [1:0] sel, input logic [ADDR_W-1:0] a, input logic [15:0] din);
    t_start = cyc;
    model_req(~req_toggle, a, sel, din);
    req_toggle = ~req_toggle;
    req_addr   = a;
    req_wr_sel = sel;
    req_din    = din;
  endtask

  task automatic cpu_finish(output logic [15:0] d, output int dc);
    dc = -1;
    for (int i = 0; i < 40 && dc < 0; i++) begin
      tick();
      if (cyc >= cur_acc) begin
        req_addr   = ADDR_W'($urandom);
        req_din    = 16'($urandom);
        req_wr_sel = 2'($urandom_range(0, 3));
      end
      if (done) dc = cyc;
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
    d = dout;
  endtask

  task automatic wait_rd();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (mem_rd) seen = 1'b1;
    end
    if (!seen) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset_mid();
    #2;
    reset_n    = 1'b0;
    req_toggle = 1'b0;
    load_wr    = 1'b0;
    for (int c = cyc; c < cyc + 40; c++) begin
      e_rd[c] = 0; e_we[c] = 0; e_done[c] = 0; e_busy[c] = 0; u_v[c] = 0;
    end
    sched_dout = 16'h0000;
    #1;
    chk("rst_ack", 32'(ack_toggle), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    free_at = cyc + 1;
  endtask

  logic [15:0] d;
  int          dc;

  initial begin
    for (int i = 0; i < 256; i++) gm[i] = init_val(i);
    repeat (3) tick();
    #2;
    reset_n = 1'b1;
    free_at = cyc + 1;
    tick();
    chk("init_ack", 32'(ack_toggle), 32'd0);
    chk("init_dout", 32'(dout), 32'd0);
    chk("init_busy", 32'(load_busy), 32'd0);
    chk("init_mem_addr", 32'(mem_addr), 32'd0);

    // Plain read of word 0x82
    cpu_start(2'b00, 25'h104, 16'h0);
    cpu_finish(d, dc);
    chk("t1_dout", 32'(d), 32'hBEEF);
    chk("t1_ack", 32'(ack_toggle), 32'd1);
    chk("t1_mem_addr", 32'(last_rd_addr), 32'h82);
    chk("t1_rd_lat", 32'(last_rd - t_start), 32'(1 + SYNC_D));
    chk("t1_done_lat", 32'(dc - last_rd), 32'd2);
    tick();
    chk("t1_done_once", 32'(done), 32'd0);

    // Upper-byte write then readback
    cpu_start(2'b10, 25'h10, 16'h12AB);
    cpu_finish(d, dc);
    chk("t2_be", 32'(last_we_be), 32'h2);
    chk("t2_wdata", 32'(last_we_wd), 32'h12AB);
    chk("t2_ack_lat", 32'(dc - last_we), 32'd1);
    chk("t2_dout_kept", 32'(d), 32'hBEEF);
    cpu_start(2'b00, 25'h10, 16'h0);
    cpu_finish(d, dc);
    chk("t2_readback", 32'(d), 32'h1256);

    // Back-to-back read, write, read
    cpu_start(2'b00, 25'h20, 16'h0);
    cpu_finish(d, dc);
    chk("t3_rd0", 32'(d), 32'h0011);
    cpu_start(2'b01, 25'h22, 16'h77CC);
    cpu_finish(d, dc);
    cpu_start(2'b00, 25'h22, 16'h0);
    cpu_finish(d, dc);
    chk("t3_rd1", 32'(d), 32'hF0CC);

    // Loader collides with a CPU read of the same word
    model_load(25'h21, 8'h5A);
    cpu_start(2'b00, 25'h20, 16'h0);
    load_wr   = 1'b1;
    load_addr = 25'h21;
    load_data = 8'h5A;
    tick();
    load_wr = 1'b0;
    cpu_finish(d, dc);
    chk("t4_ld_first", 32'(last_we - t_start), 32'd2);
    chk("t4_ld_be", 32'(last_we_be), 32'h2);
    chk("t4_ld_wdata", 32'(last_we_wd), 32'h5A5A);
    chk("t4_rd_delay", 32'(last_rd - t_start), 32'd3);
    chk("t4_dout", 32'(d), 32'h5A11);

    // Loader arrives while a read is waiting
    cpu_start(2'b00, 25'h104, 16'h0);
    wait_rd();
    model_load(25'h40, 8'h3C);
    load_wr   = 1'b1;
    load_addr = 25'h40;
    load_data = 8'h3C;
    tick();
    load_wr = 1'b0;
    cpu_finish(d, dc);
    chk("t5_dout", 32'(d), 32'hBEEF);
    cpu_start(2'b00, 25'h40, 16'h0);
    cpu_finish(d, dc);
    chk("t5_readback", 32'(d), 32'h123C);

    // Reset in the middle of a read, then a clean read
    cpu_start(2'b00, 25'h10, 16'h0);
    wait_rd();
    do_reset_mid();
    tick();
    cpu_start(2'b00, 25'h104, 16'h0);
    cpu_finish(d, dc);
    chk("t6_dout", 32'(d), 32'hBEEF);
    chk("t6_ack", 32'(ack_toggle), 32'd1);

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
